adc_lane_aligner: RTL and testbench
===================================

Name: adc_lane_aligner

Overview:
- Parametrised successor to the fixed two-lane ADC/discriminator capture channel.
- Automatically word-aligns NUM_LANES deserialised lanes of LANE_W bits each: pulses per-lane bitslip until each lane repeatedly shows TRAIN_PATTERN.
- Then reports per-lane lock and emits the concatenated sample word.
- Sits between the SERDES primitives and the sample pipeline in the lclk domain.

Parameters:
NUM_LANES, 2, number of deserialised lanes; 1..8
LANE_W, 6, bits per lane word; 4..8
TRAIN_PATTERN, 6'b111000, expected per-lane word during training; LANE_W bits wide
SETTLE_CYCLES, 4, cycles to wait after any bitslip or tap change before comparing; >=2
MATCH_COUNT, 8, consecutive matching words required to declare lock; >=1
TAP_MAX, 31, highest IDELAY tap tried when the sweep feature is enabled

Ports:
lclk  input  1  word clock; all logic on rising edge
reset  input  1  asynchronous, active-high; clears all state
start  input  1  one-cycle pulse; begins training of all lanes from lane 0
lane_bits  input  NUM_LANES*LANE_W  deserialised words; lane k at [k*LANE_W +: LANE_W]
bitslip  output  NUM_LANES  one-cycle bitslip pulse per lane
delay_ce  output  NUM_LANES  IDELAY increment-enable pulse (sweep feature only)
delay_inc  output  NUM_LANES  IDELAY direction; held 1 whenever delay_ce is pulsed
lane_locked  output  NUM_LANES  lane k aligned
busy  output  1  training in progress
done  output  1  all lanes locked; held until next start or reset
error  output  1  some lane failed; held until next start or reset
sample_out  output  NUM_LANES*LANE_W  registered lane_bits, lane NUM_LANES-1 in MSBs
sample_valid  output  1  sample_out valid; equals done delayed one cycle

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; all counters 0.
- Single shared FSM; lane index register lane_idx (clog2(NUM_LANES) bits, min 1).
- IDLE: on start, go to SETTLE.
  - Clear lane_locked, done, error, lane_idx, slip_cnt, match_cnt and tap_cnt.
  - Assert busy.
- SETTLE: count SETTLE_CYCLES cycles, then go to CHECK with match_cnt=0.
- CHECK: compare lane_bits of lane_idx with TRAIN_PATTERN.
  - Match: increment match_cnt. When it reaches MATCH_COUNT, set lane_locked[lane_idx] and go to NEXT.
  - Mismatch: go to SLIP.
- SLIP: one cycle.
  - If slip_cnt < LANE_W-1: pulse bitslip[lane_idx] once, increment slip_cnt, go to SETTLE.
  - Otherwise the lane is exhausted; go to FAIL (or TAP when the sweep feature is enabled).
- NEXT:
  - If lane_idx = NUM_LANES-1: go to DONE.
  - Otherwise: increment lane_idx, clear slip_cnt and tap_cnt, go to SETTLE.
- DONE: done=1, busy=0, return to IDLE holding done. done clears on the next start.
- FAIL: error=1, busy=0, return to IDLE holding error.
  - lane_locked keeps bits for lanes locked so far.
  - Remaining lanes are not trained.
- start while busy: ignored.
- reset mid-training: immediate return to IDLE with all outputs 0. No partial bitslip pulse survives.
- bitslip, delay_ce: never more than one bit high in any cycle; each pulse exactly one cycle wide.
- sample_out: registered every cycle from lane_bits (latency 1), independent of the FSM.
- sample_valid: registered copy of done, so the first valid word is the word captured in the cycle after done rises.

Optional Feature:
- Macro: ADC_LANE_ALIGNER_IDELAY_SWEEP_EN.
- Defined:
  - An exhausted lane enters TAP instead of FAIL.
  - If tap_cnt < TAP_MAX: pulse delay_ce[lane_idx] with delay_inc=1, increment tap_cnt, clear slip_cnt, go to SETTLE.
  - Otherwise go to FAIL.
- Undefined: TAP state and tap_cnt are not built; delay_ce and delay_inc are tied to 0.

Decomposition:
- Shared package adc_align_pkg:
  - FSM state enum (IDLE, SETTLE, CHECK, SLIP, TAP, NEXT, DONE, FAIL).
  - clog2-based width constants.
  - Default TRAIN_PATTERN constant.
- One natural sub-module, adc_lane_select: combinational mux of lane lane_idx out of lane_bits, plus pattern comparator. Everything else stays in the top.

Test Plan:
- Bench model: each lane rotates its word left one bit per bitslip pulse, taking effect 2 cycles later.
- Ideal lanes: NUM_LANES=2, LANE_W=6, both lanes already show 111000, start pulse -> no bitslip, lane_locked=2'b11, done=1 after about 2*(4+8)+4 cycles, sample_valid one cycle later.
- Lane 1 offset by 3 (shows 000111) -> bitslip[1] pulsed exactly 3 times, bitslip[0] never pulsed, done=1, error=0.
- Lane 0 stuck at 6'b101010 -> 5 bitslip[0] pulses, then error=1, done=0, lane_locked=2'b00, lane 1 untrained.
- reset asserted in SETTLE after 2 slips -> all outputs 0 at once. A fresh start retrains and reaches done=1.
- With ADC_LANE_ALIGNER_IDELAY_SWEEP_EN and lane 0 matching only after 2 tap increments -> 2 delay_ce[0] pulses, each following 5 slips, then lock and done=1.
- start pulsed while busy -> ignored, counters unchanged, single done.

Source files
------------

// File: rtl/adc_lane_aligner_pkg.sv
// Shared definitions for the ADC lane word aligner: FSM state encoding,
// counter width helpers and the default training pattern.
package adc_align_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_CHECK,
    ST_SLIP,
    ST_TAP,
    ST_NEXT,
    ST_DONE,
    ST_FAIL
  } state_t;

  localparam logic [5:0] DEFAULT_TRAIN_PATTERN = 6'b111000;

  // Width of an index selecting one of n items (at least 1 bit).
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Width of a counter that must hold values 0..max_val (at least 1 bit).
  function automatic int unsigned cnt_w(input int unsigned max_val);
    return (max_val > 0) ? $clog2(max_val + 1) : 1;
  endfunction

endpackage

// File: rtl/adc_lane_aligner_select.sv
// Lane selector: picks the word of lane lane_idx out of the packed lane bus
// and compares it with the training pattern.
module adc_lane_select
  import adc_align_pkg::*;
#(
  parameter int unsigned       NUM_LANES     = 2,
  parameter int unsigned       LANE_W        = 6,
  parameter int unsigned       IDX_W         = 1,
  parameter logic [LANE_W-1:0] TRAIN_PATTERN = LANE_W'(DEFAULT_TRAIN_PATTERN)
) (
  input  logic [NUM_LANES*LANE_W-1:0] lane_bits,
  input  logic [IDX_W-1:0]            lane_idx,
  output logic                        match
);

  logic [LANE_W-1:0] lane_word;

  // Mux the selected lane; indices past the last lane read as zero.
  always_comb begin
    lane_word = '0;
    for (int unsigned k = 0; k < NUM_LANES; k++) begin
      if (lane_idx == IDX_W'(k)) begin
        lane_word = lane_bits[k*LANE_W +: LANE_W];
      end
    end
  end

  assign match = (lane_word == TRAIN_PATTERN);

endmodule

// File: rtl/adc_lane_aligner.sv
// Automatic word aligner for NUM_LANES deserialised ADC lanes in the lclk
// domain. Trains lanes one at a time by pulsing bitslip until the lane shows
// TRAIN_PATTERN MATCH_COUNT times in a row, then reports lock/done.
// Optional IDELAY tap sweep on exhausted lanes: ADC_LANE_ALIGNER_IDELAY_SWEEP_EN.
module adc_lane_aligner
  import adc_align_pkg::*;
#(
  parameter int unsigned       NUM_LANES     = 2,
  parameter int unsigned       LANE_W        = 6,
  parameter logic [LANE_W-1:0] TRAIN_PATTERN = LANE_W'(DEFAULT_TRAIN_PATTERN),
  parameter int unsigned       SETTLE_CYCLES = 4,
  parameter int unsigned       MATCH_COUNT   = 8,
  parameter int unsigned       TAP_MAX       = 31
) (
  input  logic                        lclk,
  input  logic                        reset,
  input  logic                        start,
  input  logic [NUM_LANES*LANE_W-1:0] lane_bits,
  output logic [NUM_LANES-1:0]        bitslip,
  output logic [NUM_LANES-1:0]        delay_ce,
  output logic [NUM_LANES-1:0]        delay_inc,
  output logic [NUM_LANES-1:0]        lane_locked,
  output logic                        busy,
  output logic                        done,
  output logic                        error,
  output logic [NUM_LANES*LANE_W-1:0] sample_out,
  output logic                        sample_valid
);

  localparam int unsigned IDX_W    = idx_w(NUM_LANES);
  localparam int unsigned SETTLE_W = cnt_w(SETTLE_CYCLES);
  localparam int unsigned MATCH_W  = cnt_w(MATCH_COUNT);
  localparam int unsigned SLIP_W   = cnt_w(LANE_W);

  localparam logic [IDX_W-1:0]    LAST_LANE   = IDX_W'(NUM_LANES - 1);
  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);
  localparam logic [MATCH_W-1:0]  MATCH_LAST  = MATCH_W'(MATCH_COUNT - 1);
  localparam logic [SLIP_W-1:0]   SLIP_LAST   = SLIP_W'(LANE_W - 1);

  if (NUM_LANES < 1 || NUM_LANES > 8 || LANE_W < 4 || LANE_W > 8 ||
      SETTLE_CYCLES < 2 || MATCH_COUNT < 1 || TAP_MAX < 1) begin : g_param_check
    $error("adc_lane_aligner: parameter out of range");
  end

  state_t                state, state_n;
  logic [IDX_W-1:0]      lane_idx, lane_idx_n;
  logic [SETTLE_W-1:0]   settle_cnt, settle_n;
  logic [MATCH_W-1:0]    match_cnt, match_n;
  logic [SLIP_W-1:0]     slip_cnt, slip_n;
  logic [NUM_LANES-1:0]  locked_n, bitslip_n, lane_sel;
  logic                  busy_n, done_n, error_n;
  logic                  lane_match;

`ifdef ADC_LANE_ALIGNER_IDELAY_SWEEP_EN
  localparam int unsigned        TAP_W     = cnt_w(TAP_MAX);
  localparam logic [TAP_W-1:0]   TAP_LIMIT = TAP_W'(TAP_MAX);
  logic [TAP_W-1:0]              tap_cnt, tap_n;
  logic [NUM_LANES-1:0]          delay_ce_n;
`endif

  assign lane_sel = NUM_LANES'(1) << lane_idx;

  adc_lane_select #(
    .NUM_LANES     (NUM_LANES),
    .LANE_W        (LANE_W),
    .IDX_W         (IDX_W),
    .TRAIN_PATTERN (TRAIN_PATTERN)
  ) u_select (
    .lane_bits (lane_bits),
    .lane_idx  (lane_idx),
    .match     (lane_match)
  );

  // FSM and datapath registers; pulses are registered so reset kills them at once.
  always_ff @(posedge lclk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      lane_idx    <= '0;
      settle_cnt  <= '0;
      match_cnt   <= '0;
      slip_cnt    <= '0;
      lane_locked <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
      bitslip     <= '0;
`ifdef ADC_LANE_ALIGNER_IDELAY_SWEEP_EN
      tap_cnt     <= '0;
      delay_ce    <= '0;
      delay_inc   <= '0;
`endif
    end else begin
      state       <= state_n;
      lane_idx    <= lane_idx_n;
      settle_cnt  <= settle_n;
      match_cnt   <= match_n;
      slip_cnt    <= slip_n;
      lane_locked <= locked_n;
      busy        <= busy_n;
      done        <= done_n;
      error       <= error_n;
      bitslip     <= bitslip_n;
`ifdef ADC_LANE_ALIGNER_IDELAY_SWEEP_EN
      tap_cnt     <= tap_n;
      delay_ce    <= delay_ce_n;
      delay_inc   <= delay_ce_n;
`endif
    end
  end

  // Next-state and next-output logic for the shared training FSM.
  always_comb begin
    state_n    = state;
    lane_idx_n = lane_idx;
    settle_n   = settle_cnt;
    match_n    = match_cnt;
    slip_n     = slip_cnt;
    locked_n   = lane_locked;
    busy_n     = busy;
    done_n     = done;
    error_n    = error;
    bitslip_n  = '0;
`ifdef ADC_LANE_ALIGNER_IDELAY_SWEEP_EN
    tap_n      = tap_cnt;
    delay_ce_n = '0;
`endif
    unique case (state)
      ST_IDLE: begin
        if (start) begin
          state_n    = ST_SETTLE;
          lane_idx_n = '0;
          settle_n   = '0;
          match_n    = '0;
          slip_n     = '0;
          locked_n   = '0;
          done_n     = 1'b0;
          error_n    = 1'b0;
          busy_n     = 1'b1;
`ifdef ADC_LANE_ALIGNER_IDELAY_SWEEP_EN
          tap_n      = '0;
`endif
        end
      end
      ST_SETTLE: begin
        if (settle_cnt == SETTLE_LAST) begin
          settle_n = '0;
          match_n  = '0;
          state_n  = ST_CHECK;
        end else begin
          settle_n = settle_cnt + SETTLE_W'(1);
        end
      end
      ST_CHECK: begin
        if (lane_match) begin
          if (match_cnt == MATCH_LAST) begin
            locked_n = lane_locked | lane_sel;
            state_n  = ST_NEXT;
          end else begin
            match_n = match_cnt + MATCH_W'(1);
          end
        end else begin
          state_n = ST_SLIP;
        end
      end
      ST_SLIP: begin
        if (slip_cnt < SLIP_LAST) begin
          bitslip_n = lane_sel;
          slip_n    = slip_cnt + SLIP_W'(1);
          state_n   = ST_SETTLE;
        end else begin
`ifdef ADC_LANE_ALIGNER_IDELAY_SWEEP_EN
          state_n = ST_TAP;
`else
          state_n = ST_FAIL;
`endif
        end
      end
`ifdef ADC_LANE_ALIGNER_IDELAY_SWEEP_EN
      ST_TAP: begin
        if (tap_cnt < TAP_LIMIT) begin
          delay_ce_n = lane_sel;
          tap_n      = tap_cnt + TAP_W'(1);
          slip_n     = '0;
          state_n    = ST_SETTLE;
        end else begin
          state_n = ST_FAIL;
        end
      end
`endif
      ST_NEXT: begin
        if (lane_idx == LAST_LANE) begin
          state_n = ST_DONE;
        end else begin
          lane_idx_n = lane_idx + IDX_W'(1);
          slip_n     = '0;
          state_n    = ST_SETTLE;
`ifdef ADC_LANE_ALIGNER_IDELAY_SWEEP_EN
          tap_n      = '0;
`endif
        end
      end
      ST_DONE: begin
        done_n  = 1'b1;
        busy_n  = 1'b0;
        state_n = ST_IDLE;
      end
      ST_FAIL: begin
        error_n = 1'b1;
        busy_n  = 1'b0;
        state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

`ifndef ADC_LANE_ALIGNER_IDELAY_SWEEP_EN
  assign delay_ce  = '0;
  assign delay_inc = '0;
`endif

  // Free-running sample capture; valid trails done by one cycle.
  always_ff @(posedge lclk or posedge reset) begin
    if (reset) begin
      sample_out   <= '0;
      sample_valid <= 1'b0;
    end else begin
      sample_out   <= lane_bits;
      sample_valid <= done;
    end
  end

endmodule

// File: tb/tb_adc_lane_aligner.sv
// Self-checking bench for adc_lane_aligner (default 2 lanes x 6 bits).
// Define ADC_LANE_ALIGNER_IDELAY_SWEEP_EN to also exercise the tap sweep.
module tb_adc_lane_aligner;

  localparam int NL = 2;
  localparam int W  = 6;
  localparam int S  = 4;
  localparam int M  = 8;
  localparam logic [W-1:0] PAT = 6'b111000;

  logic            lclk  = 1'b0;
  logic            reset = 1'b1;
  logic            start = 1'b0;
  logic [NL*W-1:0] lane_bits;
  logic [NL-1:0]   bitslip, delay_ce, delay_inc, lane_locked;
  logic            busy, done, error, sample_valid;
  logic [NL*W-1:0] sample_out;

  always #5 lclk = ~lclk;

  adc_lane_aligner #(
    .NUM_LANES     (NL),
    .LANE_W        (W),
    .TRAIN_PATTERN (PAT),
    .SETTLE_CYCLES (S),
    .MATCH_COUNT   (M),
    .TAP_MAX       (31)
  ) dut (
    .lclk         (lclk),
    .reset        (reset),
    .start        (start),
    .lane_bits    (lane_bits),
    .bitslip      (bitslip),
    .delay_ce     (delay_ce),
    .delay_inc    (delay_inc),
    .lane_locked  (lane_locked),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .sample_out   (sample_out),
    .sample_valid (sample_valid)
  );

  function automatic logic [W-1:0] rotl(input logic [W-1:0] w);
    return {w[W-2:0], w[W-1]};
  endfunction

  // ---------------- lane environment (SERDES + IDELAY model) ----------------
  logic [W-1:0]    words [NL];
  int              slips_seen [NL];
  int              ce_seen [NL];
  int              taps_m [NL];
  int              good_tap [NL];
  int              cyc;
  logic [NL*W-1:0] exp_sample;
  logic [NL-1:0]   sp1, sp2, cp1, cp2;

  logic [W-1:0]    ld_words [NL];
  int              ld_good_tap [NL];
  int              ld_seq = 0;
  int              ld_seen;

  initial begin : env
    cyc = 0; ld_seen = 0;
    sp1 = '0; sp2 = '0; cp1 = '0; cp2 = '0;
    exp_sample = '0;
    for (int k = 0; k < NL; k++) begin
      words[k] = PAT; slips_seen[k] = 0; ce_seen[k] = 0; taps_m[k] = 0; good_tap[k] = -1;
      lane_bits[k*W +: W] = PAT;
    end
    forever begin
      @(posedge lclk);
      cyc++;
      exp_sample = reset ? '0 : lane_bits;
      #1;
      if (ld_seq != ld_seen) begin
        ld_seen = ld_seq;
        for (int k = 0; k < NL; k++) begin
          words[k] = ld_words[k]; good_tap[k] = ld_good_tap[k]; taps_m[k] = 0;
        end
      end
      for (int k = 0; k < NL; k++) begin
        if (sp2[k]) words[k] = rotl(words[k]);
        if (cp2[k]) begin
          taps_m[k]++;
          if (taps_m[k] == good_tap[k]) words[k] = PAT;
        end
        if (bitslip[k])  slips_seen[k]++;
        if (delay_ce[k]) ce_seen[k]++;
      end
      sp2 = sp1; cp2 = cp1; sp1 = bitslip; cp1 = delay_ce;
      for (int k = 0; k < NL; k++) lane_bits[k*W +: W] = words[k];
    end
  end

  // ---------------- expectations published by the stimulus process ----------------
  logic          armed = 1'b0;
  int            m_start = 0, m_len = 0;
  logic          m_done = 1'b0, m_err = 1'b0;
  int            end_seq = 0, to_seq = 0;
  logic [NL-1:0] exp_locked = '0;
  int            exp_slips_tot [NL];
  int            exp_ce_tot [NL];

  // ---------------- compare process ----------------
  int   n_vec, n_bad;
  logic last_exp_done;
  logic [NL-1:0] prev_slip;
  int   end_seen, to_seen;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  initial begin : cmp
    logic e_b, e_d, e_e;
    n_vec = 0; n_bad = 0; last_exp_done = 1'b0; prev_slip = '0; end_seen = 0; to_seen = 0;
    forever begin
      @(negedge lclk);
      if (reset) begin
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_locked", lane_locked, 0);
        chk("rst_bitslip", bitslip, 0);
        chk("rst_delay_ce", delay_ce, 0);
        chk("rst_sample_out", sample_out, 0);
        chk("rst_sample_valid", sample_valid, 0);
        last_exp_done = 1'b0;
      end else begin
        if (!armed) begin
          e_b = 1'b0; e_d = 1'b0; e_e = 1'b0;
        end else if (cyc < m_start + m_len) begin
          e_b = 1'b1; e_d = 1'b0; e_e = 1'b0;
        end else begin
          e_b = 1'b0; e_d = m_done; e_e = m_err;
        end
        chk("busy", busy, e_b);
        chk("done", done, e_d);
        chk("error", error, e_e);
        chk("sample_valid", sample_valid, last_exp_done);
        chk("sample_out", sample_out, exp_sample);
        chk("bitslip_onehot", ($countones(bitslip) > 1), 0);
        chk("bitslip_width", (bitslip & prev_slip), 0);
`ifdef ADC_LANE_ALIGNER_IDELAY_SWEEP_EN
        chk("delay_ce_onehot", ($countones(delay_ce) > 1), 0);
        chk("delay_inc_with_ce", (delay_ce & ~delay_inc), 0);
`else
        chk("delay_ce_tied", delay_ce, 0);
        chk("delay_inc_tied", delay_inc, 0);
`endif
        last_exp_done = e_d;
      end
      prev_slip = bitslip;
      if (end_seq != end_seen) begin
        end_seen = end_seq;
        chk("lane_locked", lane_locked, exp_locked);
        for (int k = 0; k < NL; k++) begin
          chk($sformatf("bitslip_count[%0d]", k), slips_seen[k], exp_slips_tot[k]);
          chk($sformatf("delay_ce_count[%0d]", k), ce_seen[k], exp_ce_tot[k]);
        end
      end
      if (to_seq != to_seen) begin
        to_seen = to_seq;
        chk("wait_timeout", 1, 0);
      end
    end
  end

  // ---------------- behavioural model of a full training run ----------------
  int            p_len;
  logic          p_ok;
  logic [NL-1:0] p_locked;
  int            p_slips [NL];

  // Per lane: slips needed = rotations until the pattern shows; each slip
  // costs settle + one check + the slip cycle; lock costs settle + M checks + next.
  task automatic predict();
    logic [W-1:0] t;
    int r;
    p_len = 0; p_ok = 1'b1; p_locked = '0;
    for (int k = 0; k < NL; k++) begin
      p_slips[k] = 0;
      if (p_ok) begin
        t = words[k]; r = -1;
        for (int j = 0; j < W; j++) begin
          if (r < 0 && t == PAT) r = j;
          t = rotl(t);
        end
        if (r < 0) begin
          p_len += (W-1)*(S+2) + S + 3;
          p_slips[k] = W-1;
          p_ok = 1'b0;
        end else begin
          p_len += r*(S+2) + S + M + 1;
          p_slips[k] = r;
          p_locked[k] = 1'b1;
        end
      end
    end
    if (p_ok) p_len += 1;
  endtask

  task automatic load(input logic [W-1:0] w0, input logic [W-1:0] w1, input int gt0);
    ld_words[0] = w0; ld_words[1] = w1;
    ld_good_tap[0] = gt0; ld_good_tap[1] = -1;
    ld_seq++;
    repeat (3) @(negedge lclk);
  endtask

  task automatic start_run(input int len, input logic ok, input logic [NL-1:0] locked,
                           input int sl0, input int sl1, input int ce0);
    exp_locked = locked;
    exp_slips_tot[0] = slips_seen[0] + sl0;
    exp_slips_tot[1] = slips_seen[1] + sl1;
    exp_ce_tot[0]    = ce_seen[0] + ce0;
    exp_ce_tot[1]    = ce_seen[1];
    @(negedge lclk);
    start = 1'b1;
    @(posedge lclk);
    #1;
    start   = 1'b0;
    m_start = cyc;
    m_len   = len;
    m_done  = ok;
    m_err   = !ok;
    armed   = 1'b1;
  endtask

  task automatic finish_run();
    while (cyc < m_start + m_len + 2) @(negedge lclk);
    #1;
    end_seq++;
    repeat (2) @(negedge lclk);
  endtask

  task automatic start_predicted();
    predict();
    start_run(p_len, p_ok, p_locked, p_slips[0], p_slips[1], 0);
  endtask

  task automatic poke_start();
    @(negedge lclk); start = 1'b1;
    @(negedge lclk); start = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin : stim
    int s0;
    bit hit;
    for (int k = 0; k < NL; k++) begin exp_slips_tot[k] = 0; exp_ce_tot[k] = 0; end
    repeat (3) @(posedge lclk);
    #2 reset = 1'b0;
    repeat (3) @(negedge lclk);

    // Both lanes already aligned: 2 x (4 settle + 8 checks + next) + done.
    load(PAT, PAT, -1);
    start_run(27, 1'b1, 2'b11, 0, 0, 0);
    finish_run();

    // Lane 1 three rotations off: three slips of 4+1+1 cycles each on lane 1.
    load(PAT, 6'b000111, -1);
    start_run(45, 1'b1, 2'b11, 0, 3, 0);
    finish_run();

`ifndef ADC_LANE_ALIGNER_IDELAY_SWEEP_EN
    // Lane 0 never aligns: 5 slips, then fail; lane 1 never trained.
    load(6'b101010, PAT, -1);
    start_run(37, 1'b0, 2'b00, 5, 0, 0);
    finish_run();
`endif

    // Reset while settling after the second slip, then retrain from scratch.
    load(6'b000111, PAT, -1);
    s0 = slips_seen[0];
    start_predicted();
    hit = 1'b0;
    for (int i = 0; i < 200 && !hit; i++) begin
      @(posedge lclk);
      #2;
      if (slips_seen[0] - s0 >= 2) hit = 1'b1;
    end
    if (!hit) to_seq++;
    reset = 1'b1;
    armed = 1'b0;
    repeat (2) @(posedge lclk);
    #2 reset = 1'b0;
    repeat (4) @(negedge lclk);
    start_predicted();
    finish_run();

    // Start pulses while busy are ignored: same timing, single done.
    load(PAT, 6'b100011, -1);
    start_predicted();
    repeat (9) @(negedge lclk);
    poke_start();
    repeat (13) @(negedge lclk);
    poke_start();
    finish_run();

`ifdef ADC_LANE_ALIGNER_IDELAY_SWEEP_EN
    // Lane 0 aligns only after two tap increments, each following 5 slips:
    // 2 x (5*6 + 4+1+1 + tap) + 13 + 13 + 1.
    load(6'b101010, PAT, 2);
    start_run(101, 1'b1, 2'b11, 10, 0, 2);
    finish_run();
`endif

    repeat (2) @(negedge lclk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
